// File: rtl/boot_pkg.sv
// Shared types and default geometry for the descriptor-driven boot engine.
// Descriptor layout, MSB first: type | src | dst | len.
package boot_pkg;

  localparam int P_DW     = 32;
  localparam int P_ROM_AW = 8;
  localparam int P_MEM_AW = 14;
  localparam int P_IM_AW  = 10;
  localparam int P_DM_AW  = 12;
  localparam int P_LEN_W  = 8;
  localparam int P_ROM_DW = 2 + P_MEM_AW + P_DM_AW + P_LEN_W;

  localparam int LEN_LSB  = 0;
  localparam int DST_LSB  = P_LEN_W;
  localparam int SRC_LSB  = P_LEN_W + P_DM_AW;
  localparam int TYPE_LSB = P_LEN_W + P_DM_AW + P_MEM_AW;

  typedef enum logic [1:0] {
    D_END = 2'b00,
    D_IM  = 2'b01,
    D_DM  = 2'b10,
    D_ILL = 2'b11
  } desc_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DREQ,
    S_DWAIT,
    S_DECODE,
    S_COPY,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/boot_desc_dec.sv
// Splits a latched descriptor into its fields and flags any descriptor whose
// source or destination window would run past the end of its memory.
module boot_desc_dec
  import boot_pkg::*;
#(
  parameter int ROM_DW = P_ROM_DW,
  parameter int MEM_AW = P_MEM_AW,
  parameter int IM_AW  = P_IM_AW,
  parameter int DM_AW  = P_DM_AW,
  parameter int LEN_W  = P_LEN_W
) (
  input  logic [ROM_DW-1:0] desc_i,
  output desc_type_e        dtype_o,
  output logic [MEM_AW-1:0] src_o,
  output logic [DM_AW-1:0]  dst_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              err_o
);

  localparam int DST_B  = LEN_W;
  localparam int SRC_B  = LEN_W + DM_AW;
  localparam int TYPE_B = LEN_W + DM_AW + MEM_AW;

  logic [31:0] src_end;
  logic [31:0] dst_end;
  logic        src_bad;
  logic        im_bad;
  logic        dm_bad;

  assign dtype_o = desc_type_e'(desc_i[TYPE_B +: 2]);
  assign src_o   = desc_i[SRC_B +: MEM_AW];
  assign dst_o   = desc_i[DST_B +: DM_AW];
  assign len_o   = desc_i[0 +: LEN_W];

  // 32-bit sums so an end address one past the top is seen, not wrapped
  assign src_end = 32'(src_o) + 32'(len_o) + 32'd1;
  assign dst_end = 32'(dst_o) + 32'(len_o) + 32'd1;

  assign src_bad = src_end > (32'd1 << MEM_AW);
  assign im_bad  = (dst_o[DM_AW-1:IM_AW] != '0) || (dst_end > (32'd1 << IM_AW));
  assign dm_bad  = dst_end > (32'd1 << DM_AW);

  always_comb begin
    err_o = 1'b0;
    unique case (dtype_o)
      D_END:   err_o = 1'b0;
      D_IM:    err_o = im_bad || src_bad;
      D_DM:    err_o = dm_bad || src_bad;
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/boot_loader.sv
// Boot engine: walks the ROM descriptor table and streams MEMORY words into
// IM or DM one per cycle, then reports done or error until the next reset.
//
// state  | meaning
// IDLE   | waiting for system_enable
// DREQ   | ROM read of descriptor idx
// DWAIT  | ROM data returns, latched into desc_q
// DECODE | END / error / start copy
// COPY   | one MEM read per cycle, write of previous read's data
// DRAIN  | final write, advance idx
// DONE   | table finished cleanly, sticky
// ERR    | bad descriptor or table overrun, sticky
module boot_loader
  import boot_pkg::*;
#(
  parameter int DW     = P_DW,
  parameter int ROM_AW = P_ROM_AW,
  parameter int ROM_DW = P_ROM_DW,
  parameter int MEM_AW = P_MEM_AW,
  parameter int IM_AW  = P_IM_AW,
  parameter int DM_AW  = P_DM_AW,
  parameter int LEN_W  = P_LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              system_enable_i,
  output logic              rom_enable_o,
  output logic              rom_read_o,
  output logic [ROM_AW-1:0] rom_address_o,
  input  logic [ROM_DW-1:0] rom_out_i,
  output logic              MEM_en_o,
  output logic              MEM_read_o,
  output logic              MEM_write_o,
  output logic [MEM_AW-1:0] MEM_addr_o,
  input  logic [DW-1:0]     MEM_data_i,
  output logic              IM_enable_o,
  output logic              IM_write_o,
  output logic [IM_AW-1:0]  IM_address_o,
  output logic [DW-1:0]     IM_in_o,
  output logic              DM_enable_o,
  output logic              DM_write_o,
  output logic [DM_AW-1:0]  DM_address_o,
  output logic [DW-1:0]     DM_in_o,
  output logic              boot_busy_o,
  output logic              boot_done_o,
  output logic              boot_err_o,
  output logic [15:0]       word_cnt_o
);

  state_e              state_q;
  logic [ROM_AW-1:0]   idx_q;
  logic [ROM_DW-1:0]   desc_q;
  logic                tgt_dm_q;
  logic [LEN_W-1:0]    remain_q;
  logic [DM_AW-1:0]    wr_ptr_q;
  logic [DM_AW-1:0]    wr_addr_q;
  logic                rom_rd_q;
  logic [ROM_AW-1:0]   rom_addr_q;
  logic                mem_rd_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic                im_wr_q;
  logic                dm_wr_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [15:0]         word_cnt_q;
  logic [15:0]         word_cnt_d;

  desc_type_e          dec_type;
  logic [MEM_AW-1:0]   dec_src;
  logic [DM_AW-1:0]    dec_dst;
  logic [LEN_W-1:0]    dec_len;
  logic                dec_err;

  boot_desc_dec #(
    .ROM_DW (ROM_DW),
    .MEM_AW (MEM_AW),
    .IM_AW  (IM_AW),
    .DM_AW  (DM_AW),
    .LEN_W  (LEN_W)
  ) u_dec (
    .desc_i  (desc_q),
    .dtype_o (dec_type),
    .src_o   (dec_src),
    .dst_o   (dec_dst),
    .len_o   (dec_len),
    .err_o   (dec_err)
  );

  assign word_cnt_d = (word_cnt_q == 16'hFFFF) ? word_cnt_q : word_cnt_q + 16'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      desc_q     <= '0;
      tgt_dm_q   <= 1'b0;
      remain_q   <= '0;
      wr_ptr_q   <= '0;
      wr_addr_q  <= '0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      im_wr_q    <= 1'b0;
      dm_wr_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (system_enable_i) begin
            state_q    <= S_DREQ;
            busy_q     <= 1'b1;
            rom_rd_q   <= 1'b1;
            rom_addr_q <= idx_q;
          end
        end
        S_DREQ: begin
          rom_rd_q <= 1'b0;
          state_q  <= S_DWAIT;
        end
        S_DWAIT: begin
          desc_q  <= rom_out_i;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (dec_type == D_END) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (dec_err) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tgt_dm_q   <= (dec_type == D_DM);
            remain_q   <= dec_len;
            wr_ptr_q   <= dec_dst;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= dec_src;
            state_q    <= S_COPY;
          end
        end
        S_COPY: begin
          // The read issued this cycle lands next cycle, so its write is set up now
          wr_addr_q  <= wr_ptr_q;
          wr_ptr_q   <= wr_ptr_q + DM_AW'(1);
          im_wr_q    <= !tgt_dm_q;
          dm_wr_q    <= tgt_dm_q;
          word_cnt_q <= word_cnt_d;
          if (remain_q == '0) begin
            mem_rd_q <= 1'b0;
            state_q  <= S_DRAIN;
          end else begin
            remain_q   <= remain_q - LEN_W'(1);
            mem_addr_q <= mem_addr_q + MEM_AW'(1);
          end
        end
        S_DRAIN: begin
          im_wr_q <= 1'b0;
          dm_wr_q <= 1'b0;
          if (idx_q == '1) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            idx_q      <= idx_q + ROM_AW'(1);
            rom_rd_q   <= 1'b1;
            rom_addr_q <= idx_q + ROM_AW'(1);
            state_q    <= S_DREQ;
          end
        end
        S_DONE, S_ERR: begin
          state_q <= state_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_enable_o  = rom_rd_q;
  assign rom_read_o    = rom_rd_q;
  assign rom_address_o = rom_addr_q;
  assign MEM_en_o      = mem_rd_q;
  assign MEM_read_o    = mem_rd_q;
  assign MEM_write_o   = 1'b0;
  assign MEM_addr_o    = mem_addr_q;
  assign IM_enable_o   = im_wr_q;
  assign IM_write_o    = im_wr_q;
  assign IM_address_o  = wr_addr_q[IM_AW-1:0];
  assign IM_in_o       = im_wr_q ? MEM_data_i : '0;
  assign DM_enable_o   = dm_wr_q;
  assign DM_write_o    = dm_wr_q;
  assign DM_address_o  = wr_addr_q;
  assign DM_in_o       = dm_wr_q ? MEM_data_i : '0;
  assign boot_busy_o   = busy_q;
  assign boot_done_o   = done_q;
  assign boot_err_o    = err_q;
  assign word_cnt_o    = word_cnt_q;

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Descriptor-driven boot engine; successor to the fixed MEMORY-to-IM boot copy.
- Walks a table of copy descriptors in ROM and streams words from MEMORY into IM or DM at one word per cycle.
- Holds the CPU in reset until loading finishes, then flags done or error.
- Sits between ROM/MEMORY and IM/DM ahead of top; the CPU's memory ports are muxed onto IM/DM only after boot_done.

Parameters:
DW, 32, data word width
ROM_AW, 8, ROM address width; table holds 2^ROM_AW descriptors
ROM_DW, 36, descriptor width; must equal 2+MEM_AW+DM_AW+LEN_W
MEM_AW, 14, MEMORY address width
IM_AW, 10, IM address width
DM_AW, 12, DM address width
LEN_W, 8, length field width; length = field+1, range 1..2^LEN_W words

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
system_enable  in  1  level; boot starts on the first cycle seen high in IDLE
rom_enable  out  1  ROM enable
rom_read  out  1  ROM read strobe
rom_address  out  ROM_AW  descriptor index
rom_out  in  ROM_DW  descriptor; valid 1 cycle after read
MEM_en  out  1  MEMORY enable
MEM_read  out  1  MEMORY read strobe
MEM_write  out  1  tied 0
MEM_addr  out  MEM_AW  source word address
MEM_data  in  DW  read data; valid 1 cycle after read
IM_enable  out  1  IM enable
IM_write  out  1  IM write strobe
IM_address  out  IM_AW  IM write address
IM_in  out  DW  IM write data
DM_enable  out  1  DM enable
DM_write  out  1  DM write strobe
DM_address  out  DM_AW  DM write address
DM_in  out  DW  DM write data
boot_busy  out  1  high from start until DONE/ERR
boot_done  out  1  sticky; table completed without error
boot_err  out  1  sticky; bad descriptor, range overflow or table overrun
word_cnt  out  16  total words written this boot; saturates at 16'hFFFF

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all outputs 0, counters and indices 0. Reset mid-copy aborts immediately; no further strobes.
- Descriptor fields, MSB first:
  - type[1:0]: 00 END, 01 copy to IM, 10 copy to DM, 11 illegal.
  - src[MEM_AW-1:0]
  - dst[DM_AW-1:0]; IM uses the low IM_AW bits.
  - len[LEN_W-1:0]
- FSM states: IDLE, DREQ, DWAIT, DECODE, COPY, DRAIN, DONE, ERR.
- IDLE -> DREQ when system_enable=1; set boot_busy=1.
- DREQ: rom_enable=rom_read=1, rom_address=idx; go to DWAIT.
- DWAIT: ROM data arrives; latch into the descriptor register; go to DECODE.
- DECODE:
  - END -> DONE.
  - illegal type -> ERR.
  - IM target with dst[DM_AW-1:IM_AW]!=0, or dst+len+1 > 2^IM_AW -> ERR.
  - DM target with dst+len+1 > 2^DM_AW -> ERR.
  - src+len+1 > 2^MEM_AW -> ERR.
  - otherwise load remaining=len+1 and go to COPY.
  - Range checks use full-width sums; no wrap-around is permitted.
- COPY (pipelined):
  - Each cycle, issue a MEM read at src+k.
  - Data arriving from the read issued the previous cycle is written to the target at dst+k-1; IM_in/DM_in = MEM_data.
  - Strobes are active only for the selected target.
  - After the last read is issued, go to DRAIN.
- DRAIN: write the final word; idx+1; if idx was 2^ROM_AW-1 -> ERR, else DREQ.
- Copy latency: first write 1 cycle after first read; N words take N+1 cycles. Per-descriptor overhead is DREQ+DWAIT+DECODE = 3 cycles.
- word_cnt increments on every target write strobe.
- DONE: boot_done=1, boot_busy=0; held until reset. system_enable is ignored.
- ERR: boot_err=1, boot_busy=0; held until reset. No writes after entering ERR. Words already written stay written.
- Never assert IM_write and DM_write in the same cycle. MEM_write is always 0.

Decomposition:
- Package boot_pkg:
  - descriptor type codes (END/IM/DM/ILL)
  - FSM state enum
  - field-offset constants derived from the parameters
- One sub-module, boot_desc_dec: combinational field split plus range check. Outputs: type, src, dst, len, err.

Test Plan:
1. Table {IM src=0 dst=0 len=25 (26 words), END}, MEM[i]=i+1 -> IM[0..25]=1..26, no DM writes, boot_done=1 at 3+27+3 cycles after start, word_cnt=26.
2. Table {IM src=0 dst=0 len=3, DM src=100 dst=19 len=4, END} -> IM[0..3]=MEM[0..3], DM[19..23]=MEM[100..104], word_cnt=9, DM_write and IM_write never high together.
3. Descriptor type=11 as the first entry -> boot_err=1, boot_done=0, zero write strobes, word_cnt=0.
4. DM dst=4090 len=7 (8 words, exceeds 4096) -> ERR in DECODE, no writes. IM dst=1020 len=3 (ends exactly at 1023) -> accepted, 4 writes.
5. Drop rst low during the COPY of a 20-word descriptor after 5 writes -> all strobes 0 in the same cycle, state IDLE; release rst -> a full reboot rewrites all words, word_cnt=20.
6. All 2^ROM_AW entries are valid 1-word copies with no END -> 256 writes, then boot_err=1 on overrun.
